// File: rtl/reg_8bit_ser_tx_if.sv
// Load/data request and serial-line status bundle for reg_8bit_ser_tx.
// master = requester side, slave = transmitter side.
interface reg_8bit_ser_tx_if #(
  parameter int DATA_W = 8
);
  logic              Load;
  logic [DATA_W-1:0] D;
  logic              TxD;
  logic              Busy;
  logic              Done;

  modport master (output Load, output D, input TxD, input Busy, input Done);
  modport slave  (input Load, input D, output TxD, output Busy, output Done);
endinterface

// File: rtl/reg_8bit_ser_tx.sv
// Parallel-in, serial-out transmitter: start bit, DATA_W bits LSB first, stop bit.
// Define TX_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module reg_8bit_ser_tx #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input logic              CLK,
  input logic              not_reset,
  reg_8bit_ser_tx_if.slave bus
);
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] CYC_PEN  = CW'((BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  localparam logic DONE_ON_ENTRY     = (BIT_CYCLES == 1);

`ifdef TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic r_par;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t            r_state;
  logic [DATA_W-1:0] r_sh;
  logic [BW-1:0]     r_bit;
  logic [CW-1:0]     r_cyc;
  logic              r_txd, r_busy, r_done;
  logic              w_bit_end;
  logic [DATA_W-1:0] w_sh_next;

  assign w_bit_end = (r_cyc == CYC_LAST);
  assign w_sh_next = r_sh >> 1;

  // TxD is registered, so each transition loads the value of the bit being entered.
  always_ff @(posedge CLK) begin
    if (!not_reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_bit   <= '0;
      r_cyc   <= '0;
      r_txd   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
`ifdef TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (bus.Load) begin
          r_sh    <= bus.D;
`ifdef TX_PARITY_EN
          r_par   <= ^bus.D;
`endif
          r_state <= START;
          r_busy  <= 1'b1;
          r_txd   <= 1'b0;
          r_cyc   <= '0;
          r_bit   <= '0;
        end
        START: if (w_bit_end) begin
          r_cyc   <= '0;
          r_state <= DATA;
          r_txd   <= r_sh[0];
        end else r_cyc <= r_cyc + 1'b1;
        DATA: if (w_bit_end) begin
          r_cyc <= '0;
          r_sh  <= w_sh_next;
          if (r_bit == BIT_LAST) begin
            r_bit   <= '0;
`ifdef TX_PARITY_EN
            r_state <= PARITY;
            r_txd   <= r_par;
`else
            r_state <= STOP;
            r_txd   <= 1'b1;
            r_done  <= DONE_ON_ENTRY;
`endif
          end else begin
            r_bit <= r_bit + 1'b1;
            r_txd <= w_sh_next[0];
          end
        end else r_cyc <= r_cyc + 1'b1;
`ifdef TX_PARITY_EN
        PARITY: if (w_bit_end) begin
          r_cyc   <= '0;
          r_state <= STOP;
          r_txd   <= 1'b1;
          r_done  <= DONE_ON_ENTRY;
        end else r_cyc <= r_cyc + 1'b1;
`endif
        // Done is raised one edge early so it lands on the last stop cycle.
        STOP: if (w_bit_end) begin
          r_cyc   <= '0;
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end else begin
          r_cyc  <= r_cyc + 1'b1;
          r_done <= (r_cyc == CYC_PEN);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.TxD  = r_txd;
  assign bus.Busy = r_busy;
  assign bus.Done = r_done;
endmodule

// File: tb/tb_reg_8bit_ser_tx.sv
// Scoreboard bench for reg_8bit_ser_tx: expected {TxD,Busy,Done} per cycle is queued
// when a Load is driven and popped against the DUT on each falling edge.
module tb_reg_8bit_ser_tx;
`ifdef TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int FR4 = 4 * (8 + 2 + PB);
  localparam int FR1 = 1 * (8 + 2 + PB);

  logic CLK;
  logic not_reset;
  int   checks   = 0;
  int   failures = 0;
  logic [2:0] exp_q[$];

  reg_8bit_ser_tx_if #(.DATA_W(8)) if4 ();
  reg_8bit_ser_tx_if #(.DATA_W(8)) if1 ();

  reg_8bit_ser_tx #(.DATA_W(8), .BIT_CYCLES(4)) dut4 (.CLK(CLK), .not_reset(not_reset), .bus(if4));
  reg_8bit_ser_tx #(.DATA_W(8), .BIT_CYCLES(1)) dut1 (.CLK(CLK), .not_reset(not_reset), .bus(if1));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference frame model: start 0, data LSB first, optional even parity, stop 1.
  task automatic push_frame(input logic [7:0] d, input int bc);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
`ifdef TX_PARITY_EN
    bits.push_back(^d);
`endif
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++)
      for (int c = 0; c < bc; c++)
        exp_q.push_back({bits[b], 1'b1, (b == bits.size() - 1) && (c == bc - 1)});
  endtask

  task automatic test_reset;
    not_reset = 1'b0;
    if4.Load = 1'b1; if4.D = 8'hFF;
    if1.Load = 1'b1; if1.D = 8'hFF;
    @(posedge CLK); @(posedge CLK);
    @(negedge CLK);
    checks++;
    if ({if4.TxD, if4.Busy, if4.Done} !== 3'b100) begin
      failures++; $display("FAIL reset4 got=%b exp=100", {if4.TxD, if4.Busy, if4.Done});
    end
    checks++;
    if ({if1.TxD, if1.Busy, if1.Done} !== 3'b100) begin
      failures++; $display("FAIL reset1 got=%b exp=100", {if1.TxD, if1.Busy, if1.Done});
    end
    if4.Load = 1'b0; if1.Load = 1'b0; not_reset = 1'b1;
    @(negedge CLK);
    checks++;
    if ({if4.TxD, if4.Busy, if4.Done} !== 3'b100) begin
      failures++; $display("FAIL reset_release got=%b exp=100", {if4.TxD, if4.Busy, if4.Done});
    end
  endtask

  task automatic test_frame(input logic [7:0] d, input string name);
    int n, busy_cnt, done_at;
    logic [2:0] got, e;
    exp_q.delete();
    @(negedge CLK);
    if4.Load = 1'b1; if4.D = d;
    push_frame(d, 4);
    exp_q.push_back(3'b100);
    @(negedge CLK);
    if4.Load = 1'b0; if4.D = ~d;
    n = exp_q.size(); busy_cnt = 0; done_at = -1;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      got = {if4.TxD, if4.Busy, if4.Done};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL %s cyc=%0d got=%b exp=%b", name, i + 1, got, e);
      end
      if (if4.Busy === 1'b1) busy_cnt++;
      if (if4.Done === 1'b1) done_at = i + 1;
`ifdef TX_PARITY_EN
      if (i == 36) begin
        checks++;
        if (if4.TxD !== ^d) begin
          failures++; $display("FAIL %s_parity got=%b exp=%b", name, if4.TxD, ^d);
        end
      end
`endif
    end
    checks++;
    if (busy_cnt != FR4) begin
      failures++; $display("FAIL %s_busy_len got=%0d exp=%0d", name, busy_cnt, FR4);
    end
    checks++;
    if (done_at != FR4) begin
      failures++; $display("FAIL %s_done_cycle got=%0d exp=%0d", name, done_at, FR4);
    end
  endtask

  task automatic test_back_to_back;
    int n, idle_cnt;
    logic [2:0] got, e;
    exp_q.delete();
    @(negedge CLK);
    if4.Load = 1'b1; if4.D = 8'h3C;
    push_frame(8'h3C, 4);
    exp_q.push_back(3'b100);
    push_frame(8'hC3, 4);
    exp_q.push_back(3'b100);
    @(negedge CLK);
    if4.D = 8'hC3;
    n = exp_q.size(); idle_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      got = {if4.TxD, if4.Busy, if4.Done};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL b2b cyc=%0d got=%b exp=%b", i + 1, got, e);
      end
      if (i < 2 * FR4 + 1 && if4.Busy === 1'b0) idle_cnt++;
      if (i == FR4 + 5) begin
        if4.Load = 1'b0; if4.D = 8'hFF;
      end
    end
    checks++;
    if (idle_cnt != 1) begin
      failures++; $display("FAIL b2b_gap got=%0d exp=1", idle_cnt);
    end
  endtask

  task automatic test_bit_cycles_1;
    int n, busy_cnt;
    logic [2:0] got, e;
    exp_q.delete();
    @(negedge CLK);
    if1.Load = 1'b1; if1.D = 8'hFF;
    push_frame(8'hFF, 1);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    @(negedge CLK);
    if1.Load = 1'b0;
    n = exp_q.size(); busy_cnt = 0;
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      got = {if1.TxD, if1.Busy, if1.Done};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL bc1 cyc=%0d got=%b exp=%b", i + 1, got, e);
      end
      if (if1.Busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (busy_cnt != FR1) begin
      failures++; $display("FAIL bc1_busy_len got=%0d exp=%0d", busy_cnt, FR1);
    end
  endtask

  task automatic test_mid_reset;
    int n;
    logic [2:0] got, e;
    exp_q.delete();
    @(negedge CLK);
    if4.Load = 1'b1; if4.D = 8'h00;
    push_frame(8'h00, 4);
    exp_q = exp_q[0:17];
    @(negedge CLK);
    if4.Load = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge CLK);
      got = {if4.TxD, if4.Busy, if4.Done};
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        failures++; $display("FAIL midrst_pre cyc=%0d got=%b exp=%b", i + 1, got, e);
      end
    end
    not_reset = 1'b0;
    @(negedge CLK);
    checks++;
    if ({if4.TxD, if4.Busy, if4.Done} !== 3'b100) begin
      failures++; $display("FAIL midrst_abort got=%b exp=100", {if4.TxD, if4.Busy, if4.Done});
    end
    not_reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if ({if4.TxD, if4.Busy, if4.Done} !== 3'b100) begin
        failures++; $display("FAIL midrst_idle cyc=%0d got=%b exp=100", i, {if4.TxD, if4.Busy, if4.Done});
      end
    end
    test_frame(8'h5A, "midrst_new");
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity;
    test_frame(8'h07, "parity07");
    test_frame(8'h03, "parity03");
  endtask
`endif

  initial begin
    if4.Load = 1'b0; if4.D = '0;
    if1.Load = 1'b0; if1.D = '0;
    not_reset = 1'b0;
    test_reset();
    test_frame(8'hA5, "frameA5");
    test_back_to_back();
    test_bit_cycles_1();
    test_mid_reset();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
